// File: rtl/mem_pkg.sv
// Shared types for the load result path: load size encoding and the
// in-flight queue entry layout.
package mem_pkg;

  localparam int SQN_W = 7;

  // Size code 3 is not named; it formats like a word.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } load_size_e;

  typedef struct packed {
    logic [6:0]       tag;
    logic [4:0]       nm;
    logic [SQN_W-1:0] sqN;
    logic [1:0]       shamt;
    load_size_e       size;
    logic             signExt;
    logic             noMem;      // never issued a request (exception)
    logic             exception;
    logic             killed;     // squashed by a mispredict, drop at head
    logic             dataValid;  // data present, entry may leave the head
    logic [31:0]      data;
  } lq_entry_t;

endpackage

// File: rtl/load_result_unit_if.sv
// Data-memory read port: request with ready handshake, in-order
// response with no backpressure.
interface load_result_unit_if;
  logic        MEM_req_valid;
  logic        MEM_req_ready;
  logic [29:0] MEM_req_addr;
  logic        MEM_rsp_valid;
  logic [31:0] MEM_rsp_data;

  modport master (
    output MEM_req_valid, MEM_req_addr,
    input  MEM_req_ready, MEM_rsp_valid, MEM_rsp_data
  );

  modport slave (
    input  MEM_req_valid, MEM_req_addr,
    output MEM_req_ready, MEM_rsp_valid, MEM_rsp_data
  );
endinterface

// File: rtl/load_result_unit_fmt.sv
// Load data alignment and extension: shift the word down to the byte
// offset, then truncate and extend according to size.
module load_data_fmt
  import mem_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_shamt,
  input  load_size_e  i_size,
  input  logic        i_signExt,
  output logic [31:0] o_result
);

  logic [31:0] w_word;
  assign w_word = i_data >> {i_shamt, 3'b000};

  // Truncate to the access size and fill the upper bits.
  always_comb begin
    o_result = w_word;
    case (i_size)
      SZ_B:    o_result = {{24{i_signExt & w_word[7]}},  w_word[7:0]};
      SZ_H:    o_result = {{16{i_signExt & w_word[15]}}, w_word[15:0]};
      default: o_result = w_word;
    endcase
  end

endmodule

// File: rtl/load_result_unit.sv
// Load result unit: issues word reads for incoming load uops, tracks them
// in an in-order queue, formats returned data and registers the
// writeback result. Mispredicts squash everything younger than the branch.
module load_result_unit #(
  parameter int DEPTH = 4,
  parameter int SQN_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IN_branch_valid,
  input  logic [SQN_W-1:0]  IN_branch_sqN,
  input  logic              IN_uop_valid,
  input  logic [31:0]       IN_uop_addr,
  input  logic [1:0]        IN_uop_shamt,
  input  logic [1:0]        IN_uop_size,
  input  logic              IN_uop_signExt,
  input  logic              IN_uop_exception,
  input  logic [SQN_W-1:0]  IN_uop_sqN,
  input  logic [6:0]        IN_uop_tagDst,
  input  logic [4:0]        IN_uop_nmDst,
  output logic              OUT_stall,
  load_result_unit_if.master mem,
  input  logic              IN_wb_stall,
  output logic              OUT_wb_valid,
  output logic [31:0]       OUT_wb_result,
  output logic [6:0]        OUT_wb_tagDst,
  output logic [4:0]        OUT_wb_nmDst,
  output logic [SQN_W-1:0]  OUT_wb_sqN,
  output logic              OUT_wb_exception
);
  import mem_pkg::*;

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  function automatic logic younger(input logic [SQN_W-1:0] x,
                                   input logic bv, input logic [SQN_W-1:0] bs);
    logic signed [SQN_W-1:0] d;
    d = $signed(x - bs);
    return bv && (d > 0);
  endfunction

  lq_entry_t        r_q [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic             r_wb_valid, r_wb_exception;
  logic [31:0]      r_wb_result;
  logic [6:0]       r_wb_tagDst;
  logic [4:0]       r_wb_nmDst;
  logic [SQN_W-1:0] r_wb_sqN;

  logic [PW-1:0]    w_count;
  logic             w_full, w_empty, w_in_young, w_accept;
  logic [IW-1:0]    w_wr_idx, w_rd_idx, w_rsp_idx;
  logic             w_rsp_hit, w_rsp_fill;
  lq_entry_t        w_new, w_hd;
  logic             w_hd_vld, w_hd_kill, w_wb_young, w_wb_free;
  logic             w_pop, w_pop_out;
  logic [31:0]      w_fmt, w_result;
  logic             w_unused_addr;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_count == PW'(DEPTH));
  assign w_empty    = (w_count == '0);
  assign w_wr_idx   = r_wr_ptr[IW-1:0];
  assign w_rd_idx   = r_rd_ptr[IW-1:0];
  assign w_in_young = younger(IN_uop_sqN, IN_branch_valid, IN_branch_sqN);

  // Full is judged on the registered count only, so a same-cycle pop does
  // not open a slot.
  assign w_accept  = IN_uop_valid && !w_full && !w_in_young &&
                     (IN_uop_exception || mem.MEM_req_ready);
  assign OUT_stall = IN_uop_valid && !w_accept && !w_in_young;

  assign mem.MEM_req_valid = IN_uop_valid && !IN_uop_exception && !w_full && !w_in_young;
  assign mem.MEM_req_addr  = IN_uop_addr[31:2];
  assign w_unused_addr     = ^IN_uop_addr[1:0];

  // Entry image for an accepted uop; exceptions are complete on arrival.
  always_comb begin
    w_new           = '0;
    w_new.tag       = IN_uop_tagDst;
    w_new.nm        = IN_uop_nmDst;
    w_new.sqN       = IN_uop_sqN;
    w_new.shamt     = IN_uop_shamt;
    w_new.size      = load_size_e'(IN_uop_size);
    w_new.signExt   = IN_uop_signExt;
    w_new.noMem     = IN_uop_exception;
    w_new.exception = IN_uop_exception;
    w_new.dataValid = IN_uop_exception;
  end

  // Response pointer: oldest occupied entry that issued a request and is
  // still waiting for data (killed entries included, they still own one).
  always_comb begin
    logic [PW-1:0] v_ptr;
    v_ptr     = '0;
    w_rsp_hit = 1'b0;
    w_rsp_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_ptr = r_rd_ptr + PW'(i);
      if (!w_rsp_hit && (PW'(i) < w_count) &&
          !r_q[v_ptr[IW-1:0]].noMem && !r_q[v_ptr[IW-1:0]].dataValid) begin
        w_rsp_hit = 1'b1;
        w_rsp_idx = v_ptr[IW-1:0];
      end
    end
  end
  assign w_rsp_fill = mem.MEM_rsp_valid && w_rsp_hit;

  // Effective head: an empty queue exposes the uop being accepted, and a
  // response landing on the head is seen the same cycle.
  always_comb begin
    w_hd     = r_q[w_rd_idx];
    w_hd_vld = !w_empty;
    if (w_empty) begin
      w_hd     = w_new;
      w_hd_vld = w_accept;
    end else if (w_rsp_fill && (w_rsp_idx == w_rd_idx)) begin
      w_hd.data      = mem.MEM_rsp_data;
      w_hd.dataValid = 1'b1;
    end
  end

  load_data_fmt u_fmt (
    .i_data    (w_hd.data),
    .i_shamt   (w_hd.shamt),
    .i_size    (w_hd.size),
    .i_signExt (w_hd.signExt),
    .o_result  (w_fmt)
  );
  assign w_result = w_hd.exception ? 32'h0 : w_fmt;

  assign w_hd_kill  = w_hd.killed || younger(w_hd.sqN, IN_branch_valid, IN_branch_sqN);
  assign w_wb_young = younger(r_wb_sqN, IN_branch_valid, IN_branch_sqN);
  assign w_wb_free  = !r_wb_valid || !IN_wb_stall || w_wb_young;
  assign w_pop_out  = w_hd_vld && w_hd.dataValid && !w_hd_kill && w_wb_free;
  assign w_pop      = w_hd_vld && w_hd.dataValid && (w_hd_kill || w_wb_free);

  // Queue pointers: enqueue on accept, dequeue on silent drop or writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Entry state: flush kills, response fills, accept writes a fresh entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (younger(r_q[i].sqN, IN_branch_valid, IN_branch_sqN)) r_q[i].killed <= 1'b1;
      if (w_rsp_fill) begin
        r_q[w_rsp_idx].data      <= mem.MEM_rsp_data;
        r_q[w_rsp_idx].dataValid <= 1'b1;
      end
      if (w_accept) r_q[w_wr_idx] <= w_new;
    end
  end

  // Writeback register: load on pop, hold while stalled, drop when
  // drained or squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid     <= 1'b0;
      r_wb_result    <= '0;
      r_wb_tagDst    <= '0;
      r_wb_nmDst     <= '0;
      r_wb_sqN       <= '0;
      r_wb_exception <= 1'b0;
    end else if (w_pop_out) begin
      r_wb_valid     <= 1'b1;
      r_wb_result    <= w_result;
      r_wb_tagDst    <= w_hd.tag;
      r_wb_nmDst     <= w_hd.nm;
      r_wb_sqN       <= w_hd.sqN;
      r_wb_exception <= w_hd.exception;
    end else if (w_wb_young || !IN_wb_stall) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign OUT_wb_valid     = r_wb_valid;
  assign OUT_wb_result    = r_wb_result;
  assign OUT_wb_tagDst    = r_wb_tagDst;
  assign OUT_wb_nmDst     = r_wb_nmDst;
  assign OUT_wb_sqN       = r_wb_sqN;
  assign OUT_wb_exception = r_wb_exception;

  // A response with nothing outstanding is dropped; flag it.
  a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    mem.MEM_rsp_valid |-> w_rsp_hit);

endmodule

// File: tb/tb_load_result_unit.sv
// Directed bench for load_result_unit: stimulus pushes expected writebacks
// into a scoreboard, a negedge monitor pops and compares each transfer.
module tb_load_result_unit;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        IN_branch_valid, IN_uop_valid, IN_uop_signExt, IN_uop_exception, IN_wb_stall;
  logic [6:0]  IN_branch_sqN, IN_uop_sqN, IN_uop_tagDst;
  logic [31:0] IN_uop_addr;
  logic [1:0]  IN_uop_shamt, IN_uop_size;
  logic [4:0]  IN_uop_nmDst;
  logic        OUT_stall, OUT_wb_valid, OUT_wb_exception;
  logic [31:0] OUT_wb_result;
  logic [6:0]  OUT_wb_tagDst, OUT_wb_sqN;
  logic [4:0]  OUT_wb_nmDst;

  load_result_unit_if mif();

  load_result_unit #(.DEPTH(4), .SQN_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .IN_branch_valid(IN_branch_valid), .IN_branch_sqN(IN_branch_sqN),
    .IN_uop_valid(IN_uop_valid), .IN_uop_addr(IN_uop_addr),
    .IN_uop_shamt(IN_uop_shamt), .IN_uop_size(IN_uop_size),
    .IN_uop_signExt(IN_uop_signExt), .IN_uop_exception(IN_uop_exception),
    .IN_uop_sqN(IN_uop_sqN), .IN_uop_tagDst(IN_uop_tagDst), .IN_uop_nmDst(IN_uop_nmDst),
    .OUT_stall(OUT_stall), .mem(mif.master), .IN_wb_stall(IN_wb_stall),
    .OUT_wb_valid(OUT_wb_valid), .OUT_wb_result(OUT_wb_result),
    .OUT_wb_tagDst(OUT_wb_tagDst), .OUT_wb_nmDst(OUT_wb_nmDst),
    .OUT_wb_sqN(OUT_wb_sqN), .OUT_wb_exception(OUT_wb_exception)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  sh, sz;
    logic        se, exc;
    logic [6:0]  sqn, tag;
    logic [4:0]  nm;
    logic [31:0] data, res;
  } vec_t;

  vec_t sb[$];
  int   n_tests = 0, n_fail = 0;

  function automatic vec_t mk(logic [31:0] addr, logic [1:0] sh, logic [1:0] sz, logic se,
                              logic exc, logic [6:0] sqn, logic [6:0] tag, logic [4:0] nm,
                              logic [31:0] data, logic [31:0] res);
    vec_t v;
    v.addr = addr; v.sh = sh; v.sz = sz; v.se = se; v.exc = exc;
    v.sqn = sqn; v.tag = tag; v.nm = nm; v.data = data; v.res = res;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic uop(input vec_t v);
    IN_uop_valid = 1'b1; IN_uop_addr = v.addr; IN_uop_shamt = v.sh; IN_uop_size = v.sz;
    IN_uop_signExt = v.se; IN_uop_exception = v.exc; IN_uop_sqN = v.sqn;
    IN_uop_tagDst = v.tag; IN_uop_nmDst = v.nm;
  endtask

  task automatic rsp(input logic vld, input logic [31:0] d);
    mif.MEM_rsp_valid = vld; mif.MEM_rsp_data = d;
  endtask

  task automatic branch(input logic vld, input logic [6:0] s);
    IN_branch_valid = vld; IN_branch_sqN = s;
  endtask

  // Monitor: every writeback transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && OUT_wb_valid && !IN_wb_stall) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected_sqN", {25'h0, OUT_wb_sqN}, 32'hFFFF_FFFF);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("wb_result", OUT_wb_result, e.res);
        chk("wb_tag",    {25'h0, OUT_wb_tagDst}, {25'h0, e.tag});
        chk("wb_nm",     {27'h0, OUT_wb_nmDst},  {27'h0, e.nm});
        chk("wb_sqN",    {25'h0, OUT_wb_sqN},    {25'h0, e.sqn});
        chk("wb_exc",    {31'h0, OUT_wb_exception}, {31'h0, e.exc});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  vec_t v[5];
  vec_t x;

  initial begin
    IN_uop_valid = 0; IN_uop_addr = 0; IN_uop_shamt = 0; IN_uop_size = 0;
    IN_uop_signExt = 0; IN_uop_exception = 0; IN_uop_sqN = 0; IN_uop_tagDst = 0;
    IN_uop_nmDst = 0; IN_wb_stall = 0;
    branch(0, 0); rsp(0, 0); mif.MEM_req_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid",  {31'h0, OUT_wb_valid}, 32'h0);
    chk("rst_wb_result", OUT_wb_result, 32'h0);
    chk("rst_req_valid", {31'h0, mif.MEM_req_valid}, 32'h0);
    chk("rst_stall",     {31'h0, OUT_stall}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Signed byte at offset 3
    x = mk(32'h2000_0003, 2'd3, 2'd0, 1, 0, 7'd1, 7'd5, 5'd3, 32'h80FF_FF12, 32'hFFFF_FF80);
    uop(x); #1;
    chk("sb_req_valid", {31'h0, mif.MEM_req_valid}, 32'h1);
    chk("sb_req_addr",  {2'b0, mif.MEM_req_addr}, 32'h0800_0000);
    chk("sb_stall",     {31'h0, OUT_stall}, 32'h0);
    sb.push_back(x);
    tick(); IN_uop_valid = 0; rsp(1, x.data); #1;
    chk("sb_wb_early", {31'h0, OUT_wb_valid}, 32'h0);
    tick(); rsp(0, 0); #1;
    chk("sb_wb_lat", {31'h0, OUT_wb_valid}, 32'h1);
    tick();

    // Unsigned half, response three cycles after accept
    x = mk(32'h1000_0006, 2'd2, 2'd1, 0, 0, 7'd2, 7'd6, 5'd4, 32'hBEEF_1234, 32'h0000_BEEF);
    uop(x); #1;
    chk("uh_req_valid", {31'h0, mif.MEM_req_valid}, 32'h1);
    chk("uh_req_addr",  {2'b0, mif.MEM_req_addr}, 32'h0400_0001);
    sb.push_back(x);
    tick(); IN_uop_valid = 0;
    tick(); tick(); rsp(1, x.data); #1;
    chk("uh_wb_early", {31'h0, OUT_wb_valid}, 32'h0);
    tick(); rsp(0, 0); #1;
    chk("uh_wb_lat", {31'h0, OUT_wb_valid}, 32'h1);
    tick();

    // Exception uop: no request, accepted without ready, out next cycle
    mif.MEM_req_ready = 1'b0;
    x = mk(32'h0000_0040, 2'd0, 2'd2, 0, 1, 7'd3, 7'd7, 5'd5, 32'h0, 32'h0);
    uop(x); #1;
    chk("ex_req_valid", {31'h0, mif.MEM_req_valid}, 32'h0);
    chk("ex_stall",     {31'h0, OUT_stall}, 32'h0);
    sb.push_back(x);
    tick(); IN_uop_valid = 0; #1;
    chk("ex_wb_lat", {31'h0, OUT_wb_valid}, 32'h1);
    tick();
    mif.MEM_req_ready = 1'b1;

    // Fill the queue: fifth uop stalls until one entry drains
    v[0] = mk(32'h0000_0100, 2'd0, 2'd2, 0, 0, 7'd20, 7'd20, 5'd1, 32'h1111_1111, 32'h1111_1111);
    v[1] = mk(32'h0000_0104, 2'd0, 2'd0, 1, 0, 7'd21, 7'd21, 5'd2, 32'h0000_00F0, 32'hFFFF_FFF0);
    v[2] = mk(32'h0000_0109, 2'd1, 2'd1, 1, 0, 7'd22, 7'd22, 5'd3, 32'h00F0_0F00, 32'hFFFF_F00F);
    v[3] = mk(32'h0000_010D, 2'd1, 2'd0, 0, 0, 7'd23, 7'd23, 5'd4, 32'h0000_8000, 32'h0000_0080);
    v[4] = mk(32'h0000_0111, 2'd1, 2'd3, 0, 0, 7'd24, 7'd24, 5'd5, 32'hAABB_CCDD, 32'h00AA_BBCC);
    for (int i = 0; i < 4; i++) begin
      uop(v[i]); #1;
      chk("full_acc_stall", {31'h0, OUT_stall}, 32'h0);
      sb.push_back(v[i]);
      tick();
    end
    uop(v[4]); rsp(1, v[0].data); #1;
    chk("full_stall",     {31'h0, OUT_stall}, 32'h1);
    chk("full_req_valid", {31'h0, mif.MEM_req_valid}, 32'h0);
    tick(); rsp(1, v[1].data); #1;
    chk("full_reaccept", {31'h0, OUT_stall}, 32'h0);
    chk("full_req_again", {31'h0, mif.MEM_req_valid}, 32'h1);
    sb.push_back(v[4]);
    tick(); IN_uop_valid = 0; rsp(1, v[2].data);
    tick(); rsp(1, v[3].data);
    tick(); rsp(1, v[4].data);
    tick(); rsp(0, 0);
    tick(); tick();

    // Flush: sqN 11 and 12 are younger than branch 10, only 9 writes back
    v[0] = mk(32'h0000_0200, 2'd0, 2'd2, 0, 0, 7'd9,  7'd9,  5'd9,  32'h9999_9999, 32'h9999_9999);
    v[1] = mk(32'h0000_0204, 2'd0, 2'd2, 0, 0, 7'd11, 7'd11, 5'd11, 32'hDEAD_0011, 32'hDEAD_0011);
    v[2] = mk(32'h0000_0208, 2'd0, 2'd2, 0, 0, 7'd12, 7'd12, 5'd12, 32'hDEAD_0012, 32'hDEAD_0012);
    sb.push_back(v[0]);
    for (int i = 0; i < 3; i++) begin
      uop(v[i]); #1;
      chk("fl_acc_stall", {31'h0, OUT_stall}, 32'h0);
      tick();
    end
    IN_uop_valid = 0; branch(1, 7'd10);
    tick(); branch(0, 0);
    for (int i = 0; i < 3; i++) begin
      rsp(1, v[i].data); tick();
    end
    rsp(0, 0); tick();
    // Queue must be empty again: four loads go in without a stall
    for (int i = 0; i < 4; i++) begin
      v[i] = mk(32'h0000_0300 + 32'(4 * i), 2'd0, 2'd2, 0, 0, 7'(40 + i), 7'(40 + i),
                5'(16 + i), 32'h4000_0000 + 32'(i), 32'h4000_0000 + 32'(i));
      uop(v[i]); #1;
      chk("fl_empty_stall", {31'h0, OUT_stall}, 32'h0);
      sb.push_back(v[i]);
      tick();
    end
    IN_uop_valid = 0;
    for (int i = 0; i < 4; i++) begin
      rsp(1, v[i].data); tick();
    end
    rsp(0, 0); tick(); tick();

    // Stalled result holds, then an older mispredict squashes it
    x = mk(32'h0000_0400, 2'd0, 2'd1, 1, 0, 7'd50, 7'd50, 5'd6, 32'h1234_8001, 32'hFFFF_8001);
    uop(x);
    tick(); IN_uop_valid = 0; rsp(1, x.data); IN_wb_stall = 1;
    tick(); rsp(0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_valid",  {31'h0, OUT_wb_valid}, 32'h1);
      chk("st_result", OUT_wb_result, x.res);
      chk("st_sqN",    {25'h0, OUT_wb_sqN}, 32'd50);
      if (i == 2) branch(1, 7'd49);
      tick();
    end
    branch(0, 0); #1;
    chk("st_squash", {31'h0, OUT_wb_valid}, 32'h0);
    IN_wb_stall = 0;
    tick(); tick();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
